mac_feeder: RTL

MAC_FEEDER -- requirements
Module: mac_feeder

---
 rtl/mac_feeder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mac_feeder.sv
// Matrix-product operand feeder: walks A/B memories in (i,j,k) order, feeds a
// pipelined MAC and collects one result per dot product in row-major order.
module mac_feeder #(
  parameter int DATA_W  = 16,
  parameter int K_MAX   = 4,
  parameter int M_MAX   = 4,
  parameter int N_MAX   = 4,
  parameter int MAC_LAT = 2,
  localparam int ACC_W  = 2*DATA_W + $clog2(K_MAX) + 1,
  localparam int AW_A   = $clog2(M_MAX*K_MAX),
  localparam int AW_B   = $clog2(K_MAX*N_MAX),
  localparam int MDW    = $clog2(M_MAX) + 1,
  localparam int NDW    = $clog2(N_MAX) + 1,
  localparam int KDW    = $clog2(K_MAX) + 1,
  localparam int RW     = $clog2(M_MAX),
  localparam int CW     = $clog2(N_MAX)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MDW-1:0]          m_dim,
  input  logic [NDW-1:0]          n_dim,
  input  logic [KDW-1:0]          k_dim,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    a_en,
  output logic [AW_A-1:0]         a_addr,
  input  logic [DATA_W-1:0]       a_rdata,
  output logic                    b_en,
  output logic [AW_B-1:0]         b_addr,
  input  logic [DATA_W-1:0]       b_rdata,
  output logic [DATA_W-1:0]       mac_a,
  output logic [DATA_W-1:0]       mac_b,
  output logic                    mac_clear,
  input  logic signed [ACC_W-1:0] mac_acc,
  output logic                    res_valid,
  output logic [RW-1:0]           res_row,
  output logic [CW-1:0]           res_col,
  output logic [ACC_W-1:0]        res_data
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  // Stage s of the tag pipe describes the pair addressed s cycles ago.
  localparam int D = 2 + MAC_LAT;

  typedef struct packed {
    logic          vld;
    logic          clr;
    logic          last;
    logic          fin;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } tag_t;

  state_t         state;
  logic [MDW-1:0] i_cnt, m_lat;
  logic [NDW-1:0] j_cnt, n_lat;
  logic [KDW-1:0] k_cnt, k_lat;
  logic           fetch, i_end, j_end, k_end, dims_ok;
  tag_t           tag0;
  tag_t           tag_pipe [1:D];

  assign fetch = (state == FETCH);
  assign busy  = (state != IDLE);
  assign a_en  = fetch;
  assign b_en  = fetch;
  assign i_end = (i_cnt == m_lat - MDW'(1));
  assign j_end = (j_cnt == n_lat - NDW'(1));
  assign k_end = (k_cnt == k_lat - KDW'(1));

  assign dims_ok = (m_dim != '0) && (m_dim <= MDW'(M_MAX)) &&
                   (n_dim != '0) && (n_dim <= NDW'(N_MAX)) &&
                   (k_dim != '0) && (k_dim <= KDW'(K_MAX));

  assign a_addr = fetch ? AW_A'(int'(i_cnt)*K_MAX + int'(k_cnt)) : '0;
  assign b_addr = fetch ? AW_B'(int'(k_cnt)*N_MAX + int'(j_cnt)) : '0;

  always_comb begin
    tag0      = '0;
    tag0.vld  = fetch;
    tag0.clr  = (k_cnt == '0);
    tag0.last = k_end;
    tag0.fin  = i_end && j_end && k_end;
    tag0.row  = RW'(i_cnt);
    tag0.col  = CW'(j_cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      err   <= 1'b0;
      i_cnt <= '0; j_cnt <= '0; k_cnt <= '0;
      m_lat <= '0; n_lat <= '0; k_lat <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (dims_ok) begin
            m_lat <= m_dim; n_lat <= n_dim; k_lat <= k_dim;
            i_cnt <= '0; j_cnt <= '0; k_cnt <= '0;
            state <= FETCH;
          end else begin
            err <= 1'b1;
          end
        end
        FETCH: begin
          if (k_end) begin
            k_cnt <= '0;
            if (j_end) begin
              j_cnt <= '0;
              i_cnt <= i_end ? '0 : i_cnt + MDW'(1);
              if (i_end) state <= DRAIN;
            end else begin
              j_cnt <= j_cnt + NDW'(1);
            end
          end else begin
            k_cnt <= k_cnt + KDW'(1);
          end
        end
        DRAIN: if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operands land one cycle after the read, result captured MAC_LAT later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 1; s <= D; s++) tag_pipe[s] <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_clear <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      res_row   <= '0;
      res_col   <= '0;
      res_data  <= '0;
    end else begin
      tag_pipe[1] <= tag0;
      for (int s = 2; s <= D; s++) tag_pipe[s] <= tag_pipe[s-1];
      mac_a     <= tag_pipe[1].vld ? a_rdata : '0;
      mac_b     <= tag_pipe[1].vld ? b_rdata : '0;
      mac_clear <= tag_pipe[1].vld && tag_pipe[1].clr;
      res_valid <= tag_pipe[D].vld && tag_pipe[D].last;
      done      <= tag_pipe[D].vld && tag_pipe[D].fin;
      if (tag_pipe[D].vld && tag_pipe[D].last) begin
        res_data <= mac_acc;
        res_row  <= tag_pipe[D].row;
        res_col  <= tag_pipe[D].col;
      end
    end
  end

endmodule
